// File: rtl/result_display_driver_if.sv
// Handshake/bus bundle between the ALU result bus and the scanned display driver.
interface result_display_driver_if;
  logic        load;
  logic [31:0] value;
  logic        dec_mode;
  logic        busy;
  logic        overflow;
  logic [6:0]  seg;
  logic [7:0]  digit_sel;

  modport master (
    output load, value, dec_mode,
    input  busy, overflow, seg, digit_sel
  );

  modport slave (
    input  load, value, dec_mode,
    output busy, overflow, seg, digit_sel
  );
endinterface

// File: rtl/result_display_driver.sv
// Captures a 32-bit result, builds an 8-digit hex or decimal (double-dabble)
// buffer and scans it onto one shared active-low 7-segment bus.
module result_display_driver #(
  parameter int SCAN_DIV = 50000,
  parameter bit BLANK_LZ = 1'b1
) (
  input  logic                      i_clk,
  input  logic                      i_reset,   // asynchronous, active-low
  result_display_driver_if.slave    bus
);

  localparam int              PW        = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0]   PRE_MAX   = PW'(SCAN_DIV - 1);
  // Buffer digit codes: 0..15 are hex/BCD values, 16 is the dash glyph.
  localparam logic [4:0]      CODE_DASH = 5'd16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CONVERT = 2'd1,
    ST_COMMIT  = 2'd2
  } state_t;

  // Double-dabble correction: every BCD nibble of 5 or more gets +3.
  function automatic logic [39:0] bcd_adjust(input logic [39:0] b);
    logic [39:0] r;
    r = b;
    for (int i = 0; i < 10; i++) begin
      if (r[4*i +: 4] >= 4'd5) begin
        r[4*i +: 4] = r[4*i +: 4] + 4'd3;
      end else begin
        r[4*i +: 4] = r[4*i +: 4];
      end
    end
    return r;
  endfunction

  // Active-low gfedcba glyph for a buffer digit code.
  function automatic logic [6:0] seg_code(input logic [4:0] c);
    case (c)
      5'd0:    seg_code = 7'b1000000;
      5'd1:    seg_code = 7'b1111001;
      5'd2:    seg_code = 7'b0100100;
      5'd3:    seg_code = 7'b0110000;
      5'd4:    seg_code = 7'b0011001;
      5'd5:    seg_code = 7'b0010010;
      5'd6:    seg_code = 7'b0000010;
      5'd7:    seg_code = 7'b1111000;
      5'd8:    seg_code = 7'b0000000;
      5'd9:    seg_code = 7'b0010000;
      5'd10:   seg_code = 7'b0001000;
      5'd11:   seg_code = 7'b0000011;
      5'd12:   seg_code = 7'b1000110;
      5'd13:   seg_code = 7'b0100001;
      5'd14:   seg_code = 7'b0000110;
      5'd15:   seg_code = 7'b0001110;
      5'd16:   seg_code = 7'b0111111;
      default: seg_code = 7'b1111111;
    endcase
  endfunction

  state_t            r_state;
  logic [7:0][4:0]   r_buf;
  logic [31:0]       r_bin;
  logic [39:0]       r_bcd;
  logic [4:0]        r_cnt;
  logic              r_busy;
  logic              r_overflow;
  logic [PW-1:0]     r_pre;
  logic [2:0]        r_idx;
  logic [6:0]        r_seg;
  logic [7:0]        r_digit_sel;

  logic [39:0]       w_bcd_adj;
  logic              w_wrap;
  logic [2:0]        w_next_idx;
  logic [7:0]        w_blank;
  logic              w_lz;
  logic [6:0]        w_seg_next;

  assign w_bcd_adj = bcd_adjust(r_bcd);
  assign w_wrap    = (r_pre == PRE_MAX);

  // Capture/convert/commit FSM; the visible buffer only changes on hex load or commit.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state    <= ST_IDLE;
      r_buf      <= '0;
      r_bin      <= 32'd0;
      r_bcd      <= 40'd0;
      r_cnt      <= 5'd0;
      r_busy     <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.load && bus.dec_mode) begin
            r_bin   <= bus.value;
            r_bcd   <= 40'd0;
            r_cnt   <= 5'd0;
            r_busy  <= 1'b1;
            r_state <= ST_CONVERT;
          end else if (bus.load) begin
            for (int i = 0; i < 8; i++) begin
              r_buf[i] <= {1'b0, bus.value[4*i +: 4]};
            end
            r_overflow <= 1'b0;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_CONVERT: begin
          r_bcd <= {w_bcd_adj[38:0], r_bin[31]};
          r_bin <= {r_bin[30:0], 1'b0};
          if (r_cnt == 5'd31) begin
            r_state <= ST_COMMIT;
          end else begin
            r_cnt <= r_cnt + 5'd1;
          end
        end
        ST_COMMIT: begin
          if (r_bcd[39:32] != 8'd0) begin
            r_overflow <= 1'b1;
            for (int i = 0; i < 8; i++) begin
              r_buf[i] <= CODE_DASH;
            end
          end else begin
            r_overflow <= 1'b0;
            for (int i = 0; i < 8; i++) begin
              r_buf[i] <= {1'b0, r_bcd[4*i +: 4]};
            end
          end
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Next scan index: advance only when the prescaler wraps.
  always_comb begin
    if (w_wrap) begin
      w_next_idx = r_idx + 3'd1;
    end else begin
      w_next_idx = r_idx;
    end
  end

  // Leading-zero blanking from the top digit down; digit 0 always shown, dashes never blanked.
  always_comb begin
    w_lz    = 1'b1;
    w_blank = 8'd0;
    for (int i = 7; i >= 1; i--) begin
      w_lz       = w_lz & (r_buf[i] == 5'd0);
      w_blank[i] = w_lz & BLANK_LZ;
    end
    if (w_blank[w_next_idx]) begin
      w_seg_next = 7'b1111111;
    end else begin
      w_seg_next = seg_code(r_buf[w_next_idx]);
    end
  end

  // Free-running scan: prescaler, digit index and registered seg/digit_sel.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_pre       <= '0;
      r_idx       <= 3'd0;
      r_seg       <= 7'b1000000;
      r_digit_sel <= 8'hFE;
    end else begin
      if (w_wrap) begin
        r_pre <= '0;
      end else begin
        r_pre <= r_pre + PW'(1);
      end
      r_idx       <= w_next_idx;
      r_seg       <= w_seg_next;
      r_digit_sel <= ~(8'b1 << w_next_idx);
    end
  end

  assign bus.busy      = r_busy;
  assign bus.overflow  = r_overflow;
  assign bus.seg       = r_seg;
  assign bus.digit_sel = r_digit_sel;

endmodule

// File: doc/result_display_driver.md
Name: result_display_driver

Overview:
- Sits directly downstream of the ALU computation_result bus in the multi-cycle CPU.
- On a load strobe it captures a 32-bit result and builds an 8-digit buffer, either hex (immediate) or decimal (sequential double-dabble, 32 shift cycles).
- It then time-multiplexes the buffer onto one shared active-low 7-segment bus with an active-low one-hot digit select.
- It replaces eight static decoders with a scanned, board-pin-friendly driver.

Parameters:
SCAN_DIV, 50000, clk cycles each digit stays selected; legal range ≥2.
BLANK_LZ, 1, 1 = blank leading zeros above the most-significant nonzero digit. Digit 0 is never blanked.

Ports:
clk  in  1  processor-side clock; all state on rising edge.
reset  in  1  asynchronous, active-low; asserting (0) clears all state immediately.
load  in  1  single-cycle strobe; sample value/dec_mode.
value  in  32  result to display (unsigned).
dec_mode  in  1  1 = decimal, 0 = hex; sampled with load.
busy  out  1  high while a decimal conversion is in progress.
overflow  out  1  high when the last committed decimal value exceeded 99_999_999.
seg  out  7  {g,f,e,d,c,b,a}, active-low.
digit_sel  out  8  active-low one-hot; bit i enables digit i (digit 0 = least significant).

Behaviour:
- Reset (reset=0, async): state IDLE; digit buffer all 0; overflow=0; busy=0; scan index=0; prescaler=0; digit_sel=8'hFE; seg=7'b1000000 ("0").
- FSM states: IDLE, CONVERT, COMMIT.
- IDLE, load=1, dec_mode=0: at that same edge the buffer takes value[31:0] nibbles (digit i = value[4i+3:4i]) and overflow clears to 0. State stays IDLE; busy stays 0.
- IDLE, load=1, dec_mode=1: value is latched into a shift register and the 40-bit BCD accumulator clears. Shift counter goes to 0, state goes to CONVERT, busy=1 from this edge.
- CONVERT: each edge does two steps:
  - every BCD nibble ≥5 gets +3;
  - {bcd, bin} shifts left by 1.
  - After the 32nd shift (counter=31) the state goes to COMMIT.
- COMMIT: one edge.
  - If BCD digits 9..8 are nonzero: overflow=1 and all eight buffer digits are set to code DASH.
  - Otherwise: overflow=0 and the buffer takes BCD digits 7..0.
  - State goes to IDLE; busy=0 at this edge.
- Decimal latency: load sampled at edge 0; buffer and busy=0 visible after edge 33.
- load while busy=1 (CONVERT/COMMIT) is ignored; there is no queueing.
- The display keeps showing the previous buffer until commit. No partial digits are ever shown.
- Reset mid-conversion aborts: IDLE, buffer 0, busy=0.
- Scan:
  - The prescaler counts 0..SCAN_DIV-1 continuously, independent of the FSM.
  - On wrap, the index increments 0→7→0.
  - digit_sel = ~(8'b1 << index).
  - seg is registered and updates on the same edge as digit_sel.
- Segment codes (active-low gfedcba):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110
  - DASH=0111111, BLANK=1111111.
- Leading-zero blanking (BLANK_LZ=1): digit i≥1 shows BLANK if it and all digits above it are 0. DASH digits are never blanked.

Test Plan:
- SCAN_DIV=4, reset release, no load → digit_sel cycles FE,FD,FB,…,7F,FE with 4 clks per step; seg=1000000 on digit 0 and 1111111 on digits 1-7.
- load, dec_mode=0, value=32'h1234ABCD → buffer updated next edge, busy never rises; digit 7..0 segs = 1,2,3,4,A,b,C,d codes.
- load, dec_mode=1, value=12345678 → busy high exactly 33 cycles; digits 7..0 = 1..8 decimal; overflow=0.
- load, dec_mode=1, value=100000000 → after 33 cycles overflow=1, all digits 0111111; then load hex 32'h0 → overflow=0, only digit 0 lit "0".
- Second load at cycle 10 of a decimal conversion (value=5) → ignored; result still 12345678; a load in IDLE after busy falls converts 5 (digit 0 = 0010010, rest blank).
- Assert reset at cycle 15 of a conversion → busy=0, buffer 0 and digit_sel=FE immediately (asynchronously); no commit follows after release.
